// File: rtl/fetch_pkg.sv
// fetch_sequencer shared definitions: FSM states and opcode length-decode constants.
// TRAP state exists only when FETCH_ILLEGAL_TRAP_EN is defined.
package fetch_pkg;

    localparam int LEN_HI = 7;
    localparam int LEN_LO = 6;

    localparam logic [1:0] LEN1         = 2'd1;
    localparam logic [1:0] LEN2         = 2'd2;
    localparam logic [1:0] LEN3         = 2'd3;
    localparam logic [1:0] ILLEGAL_CODE = 2'b11;

    typedef enum logic [3:0] {
        FETCH_OP,
        WAIT_OP,
        FETCH_B1,
        WAIT_B1,
        FETCH_B2,
        WAIT_B2,
        ISSUE,
        UPDATE
`ifdef FETCH_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: program memory port, execute handshake, PC control.
// master = sequencer side, slave = memory/PC/execute side.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] pc_in;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic [1:0]            instr_len;
    logic                  br_req;
    logic [ADDR_WIDTH-1:0] br_addr;
    logic                  pc_adv;
    logic                  pc_jump_en;
    logic [ADDR_WIDTH-1:0] pc_jump_addr;
    logic [1:0]            pc_instr_size;
    logic                  illegal_op;

    modport master (
        input  pc_in, mem_rdata, instr_ready, br_req, br_addr,
        output mem_rd, mem_addr, instr_valid, opcode, operand1,
        output operand2, instr_len, pc_adv, pc_jump_en,
        output pc_jump_addr, pc_instr_size, illegal_op
    );

    modport slave (
        output pc_in, mem_rdata, instr_ready, br_req, br_addr,
        input  mem_rd, mem_addr, instr_valid, opcode, operand1,
        input  operand2, instr_len, pc_adv, pc_jump_en,
        input  pc_jump_addr, pc_instr_size, illegal_op
    );

endinterface

// File: rtl/fetch_len_decode.sv
// Opcode length-field decoder, shared by fetch and decode.
// Code 11 is length 1; it is also flagged illegal when FETCH_ILLEGAL_TRAP_EN is defined.
module fetch_len_decode
    import fetch_pkg::*;
(
    input  logic [1:0] i_field,
    output logic [1:0] o_len
`ifdef FETCH_ILLEGAL_TRAP_EN
    ,
    output logic       o_illegal
`endif
);

    always_comb begin
        o_len = LEN1;
`ifdef FETCH_ILLEGAL_TRAP_EN
        o_illegal = 1'b0;
`endif
        unique case (i_field)
            2'b00:   o_len = LEN1;
            2'b01:   o_len = LEN2;
            2'b10:   o_len = LEN3;
            default: begin
                o_len = LEN1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                o_illegal = (i_field == ILLEGAL_CODE);
`endif
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads 1-3 byte instructions, issues them, steers the PC.
// Optional feature macro: FETCH_ILLEGAL_TRAP_EN (trap on opcode[7:6] == 11).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = {ADDR_WIDTH{1'b1}}
) (
    input logic                clk,
    input logic                rst,
    fetch_sequencer_if.master  bus
);

    state_t                r_state;
    logic [1:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [1:0]            r_len;
    logic                  r_valid;
    logic                  r_adv;
    logic                  r_jen;
    logic [ADDR_WIDTH-1:0] r_jaddr;
    logic [1:0]            r_size;
    logic [1:0]            w_len;
`ifdef FETCH_ILLEGAL_TRAP_EN
    logic                  w_illegal;
    logic                  r_illegal;
`endif

    // Decode straight off the memory bus so WAIT_OP can pick the next state.
    fetch_len_decode u_len_decode (
        .i_field   (bus.mem_rdata[LEN_HI:LEN_LO]),
        .o_len     (w_len)
`ifdef FETCH_ILLEGAL_TRAP_EN
        ,
        .o_illegal (w_illegal)
`endif
    );

    assign bus.mem_rd = (r_state == FETCH_OP) ||
                        (r_state == FETCH_B1) ||
                        (r_state == FETCH_B2);
    assign bus.mem_addr = bus.pc_in + {{(ADDR_WIDTH-2){1'b0}}, r_idx};

    assign bus.instr_valid   = r_valid;
    assign bus.opcode        = r_opcode;
    assign bus.operand1      = r_op1;
    assign bus.operand2      = r_op2;
    assign bus.instr_len     = r_len;
    assign bus.pc_adv        = r_adv;
    assign bus.pc_jump_en    = r_jen;
    assign bus.pc_jump_addr  = r_jaddr;
    assign bus.pc_instr_size = r_size;
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign bus.illegal_op    = r_illegal;
`else
    assign bus.illegal_op    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH_OP;
            r_idx    <= 2'd0;
            r_opcode <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_len    <= 2'd0;
            r_valid  <= 1'b0;
            r_adv    <= 1'b0;
            r_jen    <= 1'b0;
            r_jaddr  <= '0;
            r_size   <= 2'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                FETCH_OP: begin
                    r_op1   <= '0;
                    r_op2   <= '0;
                    r_state <= WAIT_OP;
                end
                WAIT_OP: begin
                    r_opcode <= bus.mem_rdata;
                    r_len    <= w_len;
`ifdef FETCH_ILLEGAL_TRAP_EN
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
                        r_adv     <= 1'b1;
                        r_jen     <= 1'b1;
                        r_jaddr   <= TRAP_VECTOR;
                        r_state   <= TRAP;
                    end else
`endif
                    if (w_len != LEN1) begin
                        r_idx   <= 2'd1;
                        r_state <= FETCH_B1;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                FETCH_B1: r_state <= WAIT_B1;
                WAIT_B1: begin
                    r_op1 <= bus.mem_rdata;
                    if (r_len == LEN3) begin
                        r_idx   <= 2'd2;
                        r_state <= FETCH_B2;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                FETCH_B2: r_state <= WAIT_B2;
                WAIT_B2: begin
                    r_op2   <= bus.mem_rdata;
                    r_valid <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        r_valid <= 1'b0;
                        r_adv   <= 1'b1;
                        r_size  <= r_len;
                        r_jen   <= bus.br_req;
                        r_jaddr <= bus.br_addr;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_adv   <= 1'b0;
                    r_jen   <= 1'b0;
                    r_jaddr <= '0;
                    r_size  <= 2'd0;
                    r_idx   <= 2'd0;
                    r_state <= FETCH_OP;
                end
`ifdef FETCH_ILLEGAL_TRAP_EN
                TRAP: begin
                    r_illegal <= 1'b0;
                    r_adv     <= 1'b0;
                    r_jen     <= 1'b0;
                    r_jaddr   <= '0;
                    r_idx     <= 2'd0;
                    r_state   <= FETCH_OP;
                end
`endif
                default: r_state <= FETCH_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random programs,
// with memory and program_counter models and an instruction-level reference.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] pc_init;
    logic [7:0] m_pc;
    logic [7:0] mem [256];
    int         errors;
    int         checks;

    fetch_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .TRAP_VECTOR (8'hFF)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk or posedge rst) begin
        if (rst)
            bus.pc_in <= pc_init;
        else if (bus.pc_adv)
            bus.pc_in <= bus.pc_jump_en ? bus.pc_jump_addr
                                        : bus.pc_in + {6'b0, bus.pc_instr_size};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction length from the opcode's top two bits; 0 means a trap.
    function automatic int ref_len(input logic [7:0] op);
        if (op[7:6] == 2'b00) return 1;
        if (op[7:6] == 2'b01) return 2;
        if (op[7:6] == 2'b10) return 3;
`ifdef FETCH_ILLEGAL_TRAP_EN
        return 0;
`else
        return 1;
`endif
    endfunction

    task automatic do_reset(input logic [7:0] pc);
        @(negedge clk);
        pc_init = pc;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pc = pc;
    endtask

    // Called at a negedge while the DUT is in FETCH_OP for the instruction at m_pc.
    task automatic exec_instr(input int stall, input bit br,
                              input logic [7:0] tgt, input bit br_early);
        logic [7:0] op, b1, b2, a;
        logic [7:0] reads [$];
        int len, cyc;
        bit done;
        op = mem[m_pc];
        len = ref_len(op);
        a = m_pc + 8'd1;
        b1 = (len >= 2) ? mem[a] : 8'h00;
        a = m_pc + 8'd2;
        b2 = (len == 3) ? mem[a] : 8'h00;
        chk("fetch_rd", {31'b0, bus.mem_rd}, 1);
        chk("fetch_addr", {24'b0, bus.mem_addr}, {24'b0, m_pc});
        if (br_early) begin
            bus.br_req = 1'b1;
            bus.br_addr = ~tgt;
        end
        cyc = 1;
        done = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.mem_rd) reads.push_back(bus.mem_addr);
            if (bus.instr_valid || bus.illegal_op) begin
                done = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("issue_seen", {31'b0, done}, 1);
        chk("read_count", reads.size(), (len == 0) ? 1 : len);
        foreach (reads[i]) begin
            a = m_pc + 8'(i);
            chk("read_addr", {24'b0, reads[i]}, {24'b0, a});
        end
        if (len == 0) begin
            chk("trap_illegal", {31'b0, bus.illegal_op}, 1);
            chk("trap_valid", {31'b0, bus.instr_valid}, 0);
            chk("trap_adv", {31'b0, bus.pc_adv}, 1);
            chk("trap_jen", {31'b0, bus.pc_jump_en}, 1);
            chk("trap_jaddr", {24'b0, bus.pc_jump_addr}, 32'hFF);
            chk("trap_cycles", cyc, 3);
            bus.br_req = 1'b0;
            m_pc = 8'hFF;
            @(negedge clk);
            chk("trap_pulse", {30'b0, bus.illegal_op, bus.pc_adv}, 0);
            return;
        end
        chk("issue_valid", {31'b0, bus.instr_valid}, 1);
        chk("issue_illegal", {31'b0, bus.illegal_op}, 0);
        chk("issue_opcode", {24'b0, bus.opcode}, {24'b0, op});
        chk("issue_op1", {24'b0, bus.operand1}, {24'b0, b1});
        chk("issue_op2", {24'b0, bus.operand2}, {24'b0, b2});
        chk("issue_len", {30'b0, bus.instr_len}, len);
        chk("issue_cycles", cyc, 2 * len + 1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            cyc++;
            chk("stall_valid", {31'b0, bus.instr_valid}, 1);
            chk("stall_opcode", {24'b0, bus.opcode}, {24'b0, op});
            chk("stall_adv", {31'b0, bus.pc_adv}, 0);
        end
        bus.instr_ready = 1'b1;
        bus.br_req = br;
        bus.br_addr = tgt;
        @(negedge clk);
        cyc++;
        bus.instr_ready = 1'b0;
        bus.br_req = 1'b0;
        bus.br_addr = 8'($urandom);
        chk("upd_adv", {31'b0, bus.pc_adv}, 1);
        chk("upd_size", {30'b0, bus.pc_instr_size}, len);
        chk("upd_jen", {31'b0, bus.pc_jump_en}, {31'b0, br});
        if (br) chk("upd_jaddr", {24'b0, bus.pc_jump_addr}, {24'b0, tgt});
        chk("upd_valid", {31'b0, bus.instr_valid}, 0);
        chk("instr_cycles", cyc, 2 * len + 2 + stall);
        m_pc = br ? tgt : m_pc + 8'(len);
        @(negedge clk);
        chk("next_adv", {31'b0, bus.pc_adv}, 0);
        chk("next_addr", {24'b0, bus.mem_addr}, {24'b0, m_pc});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        pc_init = 8'h00;
        m_pc = 8'h00;
        bus.instr_ready = 1'b0;
        bus.br_req = 1'b0;
        bus.br_addr = 8'h00;
        bus.mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h05;
        mem[8'h01] = 8'h40;
        mem[8'h02] = 8'h77;
        mem[8'h3C] = 8'hC3;
        mem[8'h10] = 8'h80;
        mem[8'h11] = 8'hAA;
        mem[8'h12] = 8'hBB;
        mem[8'hFE] = 8'h80;
        mem[8'hFF] = 8'h11;
        mem[8'h20] = 8'h41;
        mem[8'h21] = 8'h5A;

        // Reset state
        do_reset(8'h00);
        chk("rst_rd", {31'b0, bus.mem_rd}, 1);
        chk("rst_addr", {24'b0, bus.mem_addr}, 0);
        chk("rst_ctrl", {26'b0, bus.instr_valid, bus.pc_adv, bus.pc_jump_en,
                         bus.illegal_op, bus.pc_instr_size}, 0);
        chk("rst_data", {bus.opcode, bus.operand1, bus.operand2, bus.pc_jump_addr}, 0);
        chk("rst_len", {30'b0, bus.instr_len}, 0);

        // Ready stall on a 1-byte opcode, then a branch with early br_req noise
        exec_instr(3, 1'b0, 8'h00, 1'b0);
        exec_instr(0, 1'b1, 8'h3C, 1'b1);
        // Illegal opcode
        exec_instr(0, 1'b0, 8'h00, 1'b0);

        // 3-byte instruction
        do_reset(8'h10);
        exec_instr(0, 1'b0, 8'h00, 1'b0);

        // Address wrap
        do_reset(8'hFE);
        exec_instr(1, 1'b0, 8'h00, 1'b0);

        // Reset during WAIT_B1
        do_reset(8'h20);
        repeat (3) @(negedge clk);
        chk("midrst_state", {31'b0, bus.mem_rd}, 0);
        rst = 1'b1;
        #1;
        chk("midrst_clear", {bus.opcode, bus.operand1, 7'b0, bus.instr_valid}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_adv", {31'b0, bus.pc_adv}, 0);
        end
        rst = 1'b0;
        m_pc = 8'h20;
        exec_instr(0, 1'b0, 8'h00, 1'b0);

        // Random programs
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset(8'($urandom));
        for (int n = 0; n < 40; n++) begin
            exec_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                       8'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
